// File: rtl/usrt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : usrt_pkg
//  Description : Constants and types shared by the USRT transmit and receive
//                chains. These include the parity mode encodings, the data
//                width and the transmit FSM state type.
//  Revision    : 1.0  - initial release
// ============================================================================
package usrt_pkg;

  // Parity mode encodings. The value 2'b11 is not named; it behaves as none.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam int DATA_BITS = 8;
  localparam int CNT_W     = $clog2(DATA_BITS);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // True when the mode puts a parity bit into the frame.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/txframer_if.sv
`default_nettype none
// ============================================================================
//  Module      : txframer_if
//  Description : Bus between a byte producer and the USRT transmitter.
//  Ports       : i_Enable    - permit a new frame to start
//                i_Parity    - parity mode (see usrt_pkg)
//                i_Push      - one-cycle write strobe for i_Data
//                i_Data      - byte to send
//                o_Tx_Serial - serial line, idle high
//                o_Full      - holding register occupied
//                o_Busy      - frame on the line
//                o_Done      - one-cycle pulse at end of stop bit
//  Modports    : master (producer side), slave (transmitter side)
//  Revision    : 1.0  - initial release
// ============================================================================
interface txframer_if;
  import usrt_pkg::*;

  logic                 i_Enable;
  logic [1:0]           i_Parity;
  logic                 i_Push;
  logic [DATA_BITS-1:0] i_Data;
  logic                 o_Tx_Serial;
  logic                 o_Full;
  logic                 o_Busy;
  logic                 o_Done;

  modport master (
    output i_Enable, i_Parity, i_Push, i_Data,
    input  o_Tx_Serial, o_Full, o_Busy, o_Done
  );

  modport slave (
    input  i_Enable, i_Parity, i_Push, i_Data,
    output o_Tx_Serial, o_Full, o_Busy, o_Done
  );

endinterface
`default_nettype wire

// File: rtl/txparity.sv
`default_nettype none
// ============================================================================
//  Module      : txparity
//  Description : Combinational parity bit for the transmit frame. It uses the
//                same encodings as rxparity, so both ends agree.
//  Ports       : i_Data   - data byte
//                i_Mode   - parity mode (none / even / odd, 11 = none)
//                o_Parity - parity bit to transmit (0 when mode is none)
//  Revision    : 1.0  - initial release
// ============================================================================
module txparity
  import usrt_pkg::*;
(
  input  wire logic [DATA_BITS-1:0] i_Data,
  input  wire logic [1:0]           i_Mode,
  output      logic                 o_Parity
);

  always_comb begin
    o_Parity = 1'b0;
    case (i_Mode)
      PAR_EVEN: o_Parity = ^i_Data;
      PAR_ODD:  o_Parity = ~^i_Data;
      PAR_NONE: o_Parity = 1'b0;
      default:  o_Parity = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/txframer.sv
`default_nettype none
// ============================================================================
//  Module      : txframer
//  Description : USRT transmitter. It holds one byte and sends it LSB first
//                as start, 8 data bits, optional parity and stop. Each bit
//                lasts one i_Bclk period.
//  Ports       : i_Pclk  - system clock
//                i_Reset - asynchronous active-high reset
//                i_Bclk  - baud clock, sampled as a level
//                bus     - txframer_if.slave (push/enable/parity in,
//                          serial line and status out)
//  Config      : TXFRAMER_STOP2_EN - two stop bits instead of one
//  Revision    : 1.0  - initial release
// ============================================================================
module txframer
  import usrt_pkg::*;
(
  input  wire logic   i_Pclk,
  input  wire logic   i_Reset,
  input  wire logic   i_Bclk,
  txframer_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_BITS - 1);

  tx_state_t            r_state;
  logic                 r_bclk_q;
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_full;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_mode;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
`ifdef TXFRAMER_STOP2_EN
  logic                 r_stop_cnt;
`endif

  logic w_tick;
  logic w_push_ok;
  logic w_stop_end;
  logic w_load;
  logic w_par;

  // Bit boundary: first Pclk cycle that sees Bclk high after it was low.
  assign w_tick    = i_Bclk & ~r_bclk_q;
  // A push into an occupied holding register is dropped.
  assign w_push_ok = bus.i_Push & ~r_full;

`ifdef TXFRAMER_STOP2_EN
  assign w_stop_end = (r_state == ST_STOP) & w_tick & r_stop_cnt;
`else
  assign w_stop_end = (r_state == ST_STOP) & w_tick;
`endif

  // A frame starts from IDLE, or straight out of the final stop tick.
  // That second case sends frames back to back with no idle gap.
  assign w_load = w_tick & r_full & bus.i_Enable &
                  ((r_state == ST_IDLE) | w_stop_end);

  txparity u_txparity (
    .i_Data   (r_shift),
    .i_Mode   (r_mode),
    .o_Parity (w_par)
  );

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      r_state    <= ST_IDLE;
      r_bclk_q   <= 1'b0;
      r_hold     <= '0;
      r_full     <= 1'b0;
      r_shift    <= '0;
      r_mode     <= PAR_NONE;
      r_cnt      <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef TXFRAMER_STOP2_EN
      r_stop_cnt <= 1'b0;
`endif
    end else begin
      r_bclk_q <= i_Bclk;
      r_done   <= 1'b0;

      if (w_push_ok) begin
        r_hold <= bus.i_Data;
        r_full <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
        end

        ST_START: begin
          if (w_tick) begin
            r_tx    <= r_shift[0];
            r_cnt   <= '0;
            r_state <= ST_DATA;
          end
        end

        ST_DATA: begin
          if (w_tick) begin
            // r_cnt holds the index of the bit now on the line.
            // It wraps back to zero on the exit from DATA.
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CNT_LAST) begin
              if (parity_enabled(r_mode)) begin
                r_tx    <= w_par;
                r_state <= ST_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= ST_STOP;
              end
            end else begin
              r_tx <= r_shift[r_cnt + 1'b1];
            end
          end
        end

        ST_PARITY: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= ST_STOP;
          end
        end

        ST_STOP: begin
`ifdef TXFRAMER_STOP2_EN
          if (w_tick) begin
            r_stop_cnt <= ~r_stop_cnt;
          end
`endif
          if (w_stop_end) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase

      // The load overrides the IDLE/STOP assignments above. Parity mode is
      // latched here, so later changes to i_Parity do not touch this frame.
      if (w_load) begin
        r_shift <= r_hold;
        r_mode  <= bus.i_Parity;
        r_full  <= 1'b0;
        r_tx    <= 1'b0;
        r_busy  <= 1'b1;
        r_state <= ST_START;
      end
    end
  end

  assign bus.o_Tx_Serial = r_tx;
  assign bus.o_Full      = r_full;
  assign bus.o_Busy      = r_busy;
  assign bus.o_Done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_txframer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_txframer
//  Description : Self-checking bench for txframer. The serial line is sampled
//                in the middle of every bit (falling i_Bclk) and compared with
//                frames built from the byte, parity mode and stop-bit count.
//  Config      : TXFRAMER_STOP2_EN - expects two stop bits when defined
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_txframer;
  import usrt_pkg::*;

  logic i_Pclk;
  logic i_Reset;
  logic i_Bclk;

  txframer_if ifc();

  txframer dut (
    .i_Pclk  (i_Pclk),
    .i_Reset (i_Reset),
    .i_Bclk  (i_Bclk),
    .bus     (ifc.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;
  logic line_q[$];

  initial begin
    i_Pclk = 1'b0;
    forever #5 i_Pclk = ~i_Pclk;
  end

  // The Bclk edges are offset from the Pclk edges.
  initial begin
    i_Bclk = 1'b0;
    #3;
    forever #80 i_Bclk = ~i_Bclk;
  end

  always @(negedge i_Bclk) line_q.push_back(ifc.o_Tx_Serial);
  always @(negedge i_Pclk) if (ifc.o_Done === 1'b1) done_cnt++;

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference frame: bit i of the result is the i-th bit on the line.
  function automatic logic [31:0] model_frame(input logic [7:0] d,
                                              input logic [1:0] m,
                                              output int len);
    logic [31:0] f;
    int p;
    f = '0;
    p = 0;
    f[p] = 1'b0; p++;
    for (int i = 0; i < 8; i++) begin
      f[p] = d[i]; p++;
    end
    if (m == 2'b01) begin
      f[p] = ^d; p++;
    end else if (m == 2'b10) begin
      f[p] = ~^d; p++;
    end
    f[p] = 1'b1; p++;
`ifdef TXFRAMER_STOP2_EN
    f[p] = 1'b1; p++;
`endif
    len = p;
    return f;
  endfunction

  function automatic int count_zeros(input int from);
    int z;
    z = 0;
    for (int i = from; i < line_q.size(); i++)
      if (line_q[i] !== 1'b1) z++;
    return z;
  endfunction

  task automatic wait_bits(input int n);
    repeat (n) @(negedge i_Bclk);
  endtask

  task automatic wait_busy(input string tag);
    int n;
    n = 0;
    while (ifc.o_Busy !== 1'b1 && n < 400) begin
      @(negedge i_Pclk);
      n++;
    end
    check_eq({tag, "_busy_timeout"}, 32'(n < 400), 32'd1);
  endtask

  // Push just after a mid-bit sample. The start bit must then be the very
  // next sample taken.
  task automatic push_byte(input logic [7:0] d, output int base);
    @(negedge i_Bclk);
    @(negedge i_Pclk);
    base = line_q.size();
    ifc.i_Data = d;
    ifc.i_Push = 1'b1;
    @(negedge i_Pclk);
    ifc.i_Push = 1'b0;
  endtask

  task automatic check_frame(input string tag, input int base,
                             input logic [31:0] exp, input int len);
    int k;
    logic [31:0] got;
    k = -1;
    got = '0;
    for (int i = base; i < line_q.size(); i++)
      if (line_q[i] === 1'b0) begin
        k = i;
        break;
      end
    check_eq({tag, "_start_delay"}, (k < 0) ? 32'hFFFF_FFFF : 32'(k - base), 32'd0);
    for (int i = 0; i < len; i++)
      got[i] = (k >= 0 && k + i < line_q.size()) ? line_q[k + i] : 1'bx;
    check_eq({tag, "_bits"}, got, exp);
    if (k >= 0) check_eq({tag, "_idle_after"}, 32'(count_zeros(k + len)), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] d, input logic [1:0] m,
                           input string tag);
    int base, len, d0;
    logic [31:0] exp;
    ifc.i_Parity = m;
    d0 = done_cnt;
    exp = model_frame(d, m, len);
    push_byte(d, base);
    wait_busy(tag);
    // A mode change mid-frame must not affect the frame already running.
    ifc.i_Parity = 2'($urandom_range(0, 3));
    wait_bits(len + 3);
    check_frame(tag, base, exp, len);
    check_eq({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check_eq({tag, "_busy_end"}, 32'(ifc.o_Busy), 32'd0);
    check_eq({tag, "_full_end"}, 32'(ifc.o_Full), 32'd0);
  endtask

  initial begin
    int base, len1, len2, d0;
    logic [31:0] e1, e2;
    logic [7:0] rd;

    i_Reset      = 1'b1;
    ifc.i_Enable = 1'b1;
    ifc.i_Parity = 2'b00;
    ifc.i_Push   = 1'b0;
    ifc.i_Data   = 8'h00;
    repeat (3) @(negedge i_Pclk);
    check_eq("reset_line", 32'(ifc.o_Tx_Serial), 32'd1);
    check_eq("reset_full", 32'(ifc.o_Full), 32'd0);
    check_eq("reset_busy", 32'(ifc.o_Busy), 32'd0);
    check_eq("reset_done", 32'(ifc.o_Done), 32'd0);
    i_Reset = 1'b0;
    wait_bits(2);

    run_frame(8'h35, 2'b01, "even_35");
    run_frame(8'h5D, 2'b10, "odd_5d");
    run_frame(8'hA5, 2'b00, "none_a5");
    run_frame(8'h00, 2'b10, "odd_00");
    run_frame(8'hFF, 2'b01, "even_ff");
    run_frame(8'h3C, 2'b11, "mode11_3c");

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom);
      run_frame(rd, 2'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    // Back-to-back frames: 0x22 is queued while 0x11 is on the line, and
    // 0x33 arrives while the holding register is full, so it is dropped.
    ifc.i_Parity = 2'b01;
    d0 = done_cnt;
    e1 = model_frame(8'h11, 2'b01, len1);
    e2 = model_frame(8'h22, 2'b01, len2);
    push_byte(8'h11, base);
    wait_busy("b2b");
    @(negedge i_Pclk);
    ifc.i_Data = 8'h22;
    ifc.i_Push = 1'b1;
    @(negedge i_Pclk);
    ifc.i_Data = 8'h33;
    @(negedge i_Pclk);
    ifc.i_Push = 1'b0;
    check_eq("b2b_full", 32'(ifc.o_Full), 32'd1);
    wait_bits(len1 + len2 + 4);
    check_frame("b2b", base, e1 | (e2 << len1), len1 + len2);
    check_eq("b2b_done_pulses", 32'(done_cnt - d0), 32'd2);
    check_eq("b2b_full_end", 32'(ifc.o_Full), 32'd0);

    // Enable low: the byte is held, and the line stays idle.
    ifc.i_Enable = 1'b0;
    ifc.i_Parity = 2'b01;
    e1 = model_frame(8'h35, 2'b01, len1);
    push_byte(8'h35, base);
    wait_bits(3);
    check_eq("en0_line_idle", 32'(count_zeros(base)), 32'd0);
    check_eq("en0_full", 32'(ifc.o_Full), 32'd1);
    check_eq("en0_busy", 32'(ifc.o_Busy), 32'd0);
    @(negedge i_Bclk);
    @(negedge i_Pclk);
    base = line_q.size();
    d0 = done_cnt;
    ifc.i_Enable = 1'b1;
    wait_bits(len1 + 3);
    check_frame("en1", base, e1, len1);
    check_eq("en1_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Reset during data bit 3, with a second byte waiting in the holder.
    ifc.i_Parity = 2'b01;
    push_byte(8'h35, base);
    wait_busy("rst");
    @(negedge i_Pclk);
    ifc.i_Data = 8'h77;
    ifc.i_Push = 1'b1;
    @(negedge i_Pclk);
    ifc.i_Push = 1'b0;
    repeat (4) @(posedge i_Bclk);
    #40;
    check_eq("rst_pre_bit3", 32'(ifc.o_Tx_Serial), 32'd0);
    check_eq("rst_pre_full", 32'(ifc.o_Full), 32'd1);
    i_Reset = 1'b1;
    #1;
    check_eq("rst_line", 32'(ifc.o_Tx_Serial), 32'd1);
    check_eq("rst_full", 32'(ifc.o_Full), 32'd0);
    check_eq("rst_busy", 32'(ifc.o_Busy), 32'd0);
    check_eq("rst_done", 32'(ifc.o_Done), 32'd0);
    #20;
    @(negedge i_Pclk);
    i_Reset = 1'b0;
    base = line_q.size();
    wait_bits(3);
    check_eq("rst_held_dropped", 32'(count_zeros(base)), 32'd0);
    run_frame(8'h35, 2'b01, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/txframer.md
# txframer

Transmit half of the USRT. Accepts one byte from the bus into a single-entry holding register, then serialises it LSB-first on `o_Tx_Serial`, paced by the baud generator's `o_Bclk`. The frame is start bit, 8 data bits, optional parity, and stop bit. Frames are bit-compatible with the receive chain `rxshift`/`rxparity`/`rxdatreg`, so the two ends can be looped back on one bench.

## Interface
- No parameters. Frame constants come from the shared package.
- `i_Pclk` in 1: system clock; all state is updated on its rising edge.
- `i_Reset` in 1: asynchronous, active-high reset.
- `i_Bclk` in 1: baud clock from `baudgen`, treated as a level. One bit period equals one `i_Bclk` period.
- `i_Enable` in 1: permits starting a new frame.
- `i_Parity` in 2: parity mode, `00` none, `01` even, `10` odd, `11` treated as none.
- `i_Push` in 1: write strobe for `i_Data`, one `i_Pclk` cycle.
- `i_Data` in 8: byte to send.
- `o_Tx_Serial` out 1: serial line, idle high.
- `o_Full` out 1: the holding register holds an unsent byte.
- `o_Busy` out 1: a frame is on the line (start through stop).
- `o_Done` out 1: one-cycle pulse at the end of the stop bit.

## Operation
- Reset values: `o_Tx_Serial`=1, `o_Full`=0, `o_Busy`=0, `o_Done`=0, FSM in IDLE, `bclk_q`=0.
- Bit tick: `tick = i_Bclk & ~bclk_q`, where `bclk_q` is `i_Bclk` registered on `i_Pclk`. All line changes happen only on tick cycles.
- Push handling:
  - `i_Push` with `o_Full`=0 captures `i_Data` and sets `o_Full` on the next edge.
  - `i_Push` with `o_Full`=1 is dropped, with no side effects. This includes the cycle in which the holding register is transferred to the shifter. The producer must honour `o_Full`.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on tick when `o_Full` & `i_Enable`. In that cycle the shifter is loaded, `i_Parity` is latched, `o_Full` is cleared, the line is driven to 0, and `o_Busy` is set.
  - START → DATA on tick: the line carries bit 0.
  - DATA: each tick outputs the next bit. After bit 7 the next tick goes to PARITY (latched mode even/odd) or STOP (mode none).
  - PARITY → STOP on tick. The line carries the parity bit: even gives XOR of the data bits; odd gives its inverse.
  - STOP: the line is 1. On the next tick `o_Done` pulses and the FSM goes to IDLE. If `o_Full` & `i_Enable` in that same cycle, it takes the IDLE→START action immediately (back-to-back frames, no idle gap).
- The bit counter is 3 bits and wraps 7→0 on the DATA exit.
- `i_Enable` dropping mid-frame does not abort the frame; it only blocks the next start. The held byte is retained.
- `i_Parity` changes mid-frame have no effect until the next load.
- Reset mid-frame: the line returns to 1 asynchronously, and the frame and held byte are discarded.

## Timing
- The line changes on the first `i_Pclk` edge that samples `i_Bclk` high after it was low.
- Push to start bit: the first tick after `o_Full` rises, i.e. at most one `i_Bclk` period plus one `i_Pclk` cycle.
- Frame length: 11 bit periods with parity, 10 without.
- `o_Busy` falls, and `o_Done` pulses, on the tick ending the stop bit.

## Configuration
- `TXFRAMER_STOP2_EN` defined: STOP lasts two bit periods, using a one-bit stop counter. Frames are 12 or 11 bits, and `o_Done` fires after the second stop bit.
- Not defined: a single stop bit, as described above.

## Structure
- Package `usrt_pkg` holds:
  - parity encodings `PAR_NONE`=2'b00, `PAR_EVEN`=2'b01, `PAR_ODD`=2'b10;
  - `DATA_BITS`=8;
  - the FSM state typedef `tx_state_t`.
- One sub-module, `txparity`: combinational parity bit from the 8-bit data and the 2-bit mode. It mirrors `rxparity`, and both use the same package constants.

## Test plan
- Even parity, push 0x35 while idle → line sequence 0,1,0,1,0,1,1,0,0,0,1, one bit per `i_Bclk` period. `rxshift` plus `rxparity` in loopback deliver 0x35. `o_Done` pulses once.
- Odd parity, push 0x5D → 0,1,0,1,1,1,0,1,0,0,1, matching receive frame 11'b10010111010. The receiver accepts 0x5D.
- Parity none, push 0xA5 → 10-bit frame 0,1,0,1,0,0,1,0,1,1. No parity bit appears.
- Push 0x11, then 0x22 while busy, then 0x33 while `o_Full`=1 → 0x33 is dropped. The frames for 0x11 and 0x22 go back-to-back, with the start bit directly after the stop bit.
- `i_Enable`=0 with 0x35 pushed → the line stays 1 and `o_Full`=1. Raise `i_Enable` → the frame starts on the next tick.
- Assert `i_Reset` during DATA bit 3 → the line is 1 immediately and `o_Full`/`o_Busy`/`o_Done` are 0. The next push transmits a clean frame.
